// File: rtl/alu_exec_unit.sv
// MIPS execute stage: ALU-control decode, single-cycle W-bit ALU and an iterative
// mult/div engine with HI/LO, fronted by a ready/valid issue port.
module alu_exec_unit #(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     aluop,
    input  logic [5:0]     funct,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [SHW-1:0] shamt,
    output logic           out_valid,
    output logic [W-1:0]   result,
    output logic [3:0]     aluctl,
    output logic           ovf,
    output logic           zero,
    output logic           md_done,
    output logic [W-1:0]   hi,
    output logic [W-1:0]   lo
);
    localparam logic [3:0] C_AND  = 4'd0,  C_OR   = 4'd1,  C_ADD  = 4'd2,  C_SLL = 4'd3;
    localparam logic [3:0] C_SRL  = 4'd4,  C_SRA  = 4'd5,  C_SUB  = 4'd6,  C_SLT = 4'd7;
    localparam logic [3:0] C_SLTU = 4'd8,  C_MFHI = 4'd9,  C_MFLO = 4'd10, C_NOR = 4'd12;
    localparam logic [3:0] C_XOR  = 4'd13, C_MD   = 4'd14, C_ILL  = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t         r_state, w_state_next;
    logic [3:0]     w_ctl;
    logic           w_accept, w_is_md, w_ovf;
    logic [W-1:0]   w_sum, w_diff, w_result;

    logic           r_out_valid, r_ovf, r_md_done;
    logic [3:0]     r_aluctl;
    logic [W-1:0]   r_result, r_hi, r_lo;

    logic           r_is_div, r_neg_res, r_neg_rem, r_b_zero;
    logic [SHW-1:0] r_cnt;
    logic [W-1:0]   r_ph, r_pl, r_md_b;
    logic           w_neg_a, w_neg_b;
    logic [W-1:0]   w_mag_a, w_mag_b, w_quo, w_rem;
    logic [W:0]     w_madd, w_shift, w_trial;
    logic [2*W-1:0] w_prod_fix;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_ctl = C_ILL;
        case (aluop)
            2'd1: w_ctl = C_SUB;
            2'd2: begin
                case (funct)
                    6'h20, 6'h21: w_ctl = C_ADD;
                    6'h22, 6'h23: w_ctl = C_SUB;
                    6'h24:        w_ctl = C_AND;
                    6'h25:        w_ctl = C_OR;
                    6'h26:        w_ctl = C_XOR;
                    6'h27:        w_ctl = C_NOR;
                    6'h2A:        w_ctl = C_SLT;
                    6'h2B:        w_ctl = C_SLTU;
                    6'h00:        w_ctl = C_SLL;
                    6'h02:        w_ctl = C_SRL;
                    6'h03:        w_ctl = C_SRA;
                    6'h10:        w_ctl = C_MFHI;
                    6'h12:        w_ctl = C_MFLO;
                    6'h18, 6'h19, 6'h1A, 6'h1B: w_ctl = C_MD;
                    default:      w_ctl = C_ILL;
                endcase
            end
            default: w_ctl = C_ADD;
        endcase
    end

    assign w_accept = in_valid && in_ready;
    assign w_is_md  = (w_ctl == C_MD);
    assign w_sum    = a + b;
    assign w_diff   = a - b;

    // Overflow is only reported for the trapping add/sub encodings.
    always_comb begin
        w_ovf = 1'b0;
        if (aluop == 2'd2 && funct == 6'h20)
            w_ovf = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
        else if (aluop == 2'd2 && funct == 6'h22)
            w_ovf = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
    end

    always_comb begin
        w_result = '0;
        case (w_ctl)
            C_AND:   w_result = a & b;
            C_OR:    w_result = a | b;
            C_ADD:   w_result = w_sum;
            C_SUB:   w_result = w_diff;
            C_XOR:   w_result = a ^ b;
            C_NOR:   w_result = ~(a | b);
            C_SLT:   w_result = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            C_SLTU:  w_result = {{(W-1){1'b0}}, a < b};
            C_SLL:   w_result = b << shamt;
            C_SRL:   w_result = b >> shamt;
            C_SRA:   w_result = $signed(b) >>> shamt;
            C_MFHI:  w_result = r_hi;
            C_MFLO:  w_result = r_lo;
            default: w_result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_aluctl    <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_result <= w_result;
                r_aluctl <= w_ctl;
                r_ovf    <= w_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_md) w_state_next = S_ITER;
            S_ITER:  if (r_cnt == SHW'(W-1))  w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_IDLE);
    end

    // funct[0] selects the unsigned variant; the most-negative value negates to itself,
    // which read as unsigned is exactly 2^(W-1).
    assign w_neg_a = !funct[0] && a[W-1];
    assign w_neg_b = !funct[0] && b[W-1];
    assign w_mag_a = w_neg_a ? -a : a;
    assign w_mag_b = w_neg_b ? -b : b;

    assign w_madd  = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_md_b} : '0);
    assign w_shift = {r_ph, r_pl[W-1]};
    assign w_trial = w_shift - {1'b0, r_md_b};

    assign w_prod_fix = r_neg_res ? -{r_ph, r_pl} : {r_ph, r_pl};
    assign w_quo      = r_b_zero ? '1 : (r_neg_res ? -r_pl : r_pl);
    assign w_rem      = r_neg_rem ? -r_ph : r_ph;

    // r_ph/r_pl hold the running partial product, or remainder/quotient when dividing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_cnt     <= '0;
            r_ph      <= '0;
            r_pl      <= '0;
            r_md_b    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_md_done <= 1'b0;
        end else begin
            r_md_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_md) begin
                        r_is_div  <= funct[1];
                        r_neg_res <= w_neg_a ^ w_neg_b;
                        r_neg_rem <= w_neg_a;
                        r_b_zero  <= (b == '0);
                        r_cnt     <= '0;
                        r_ph      <= '0;
                        r_pl      <= w_mag_a;
                        r_md_b    <= w_mag_b;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_ph <= w_trial[W] ? w_shift[W-1:0] : w_trial[W-1:0];
                        r_pl <= {r_pl[W-2:0], ~w_trial[W]};
                    end else begin
                        r_ph <= w_madd[W:1];
                        r_pl <= {w_madd[0], r_pl[W-1:1]};
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign aluctl    = r_aluctl;
    assign ovf       = r_ovf;
    assign zero      = r_out_valid && (r_result == '0);
    assign md_done   = r_md_done;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: issue tasks push expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_alu_exec_unit;
    localparam int W   = 32;
    localparam int SHW = 5;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   ctl;
        logic         ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst, in_valid, in_ready;
    logic [1:0]     aluop;
    logic [5:0]     funct;
    logic [W-1:0]   a, b;
    logic [SHW-1:0] shamt;
    logic           out_valid, ovf, zero, md_done;
    logic [W-1:0]   result, hi, lo;
    logic [3:0]     aluctl;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_stalls;

    always #5 clk = ~clk;

    alu_exec_unit #(.W(W), .SHW(SHW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid), .result(result), .aluctl(aluctl), .ovf(ovf),
        .zero(zero), .md_done(md_done), .hi(hi), .lo(lo)
    );

    function automatic exp_t mk(input logic [W-1:0] r, input logic [3:0] c, input logic o);
        exp_t e;
        e.res = r; e.ctl = c; e.ovf = o;
        return e;
    endfunction

    function automatic exp_t alu_model(input logic [1:0] op, input logic [5:0] fn,
                                       input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [SHW-1:0] sh);
        exp_t   e;
        longint s;
        e = '0;
        if (op == 2'd1) begin e.res = x - y; e.ctl = 4'd6; return e; end
        if (op != 2'd2) begin e.res = x + y; e.ctl = 4'd2; return e; end
        case (fn)
            6'h20: begin
                s = longint'($signed(x)) + longint'($signed(y));
                e.res = 32'(s); e.ctl = 4'd2;
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            6'h21: begin e.res = x + y; e.ctl = 4'd2; end
            6'h22: begin
                s = longint'($signed(x)) - longint'($signed(y));
                e.res = 32'(s); e.ctl = 4'd6;
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            6'h23: begin e.res = x - y; e.ctl = 4'd6; end
            6'h24: begin e.res = x & y; e.ctl = 4'd0; end
            6'h25: begin e.res = x | y; e.ctl = 4'd1; end
            6'h26: begin e.res = x ^ y; e.ctl = 4'd13; end
            6'h27: begin e.res = ~(x | y); e.ctl = 4'd12; end
            6'h2A: begin e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; e.ctl = 4'd7; end
            6'h2B: begin e.res = (x < y) ? 32'd1 : 32'd0; e.ctl = 4'd8; end
            6'h00: begin e.res = y << sh; e.ctl = 4'd3; end
            6'h02: begin e.res = y >> sh; e.ctl = 4'd4; end
            6'h03: begin e.res = $signed(y) >>> sh; e.ctl = 4'd5; end
            default: begin e.res = '0; e.ctl = 4'd15; end
        endcase
        return e;
    endfunction

    task automatic md_model(input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y,
                            output logic [W-1:0] h, output logic [W-1:0] l);
        longint     sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        h = '0; l = '0;
        case (fn)
            6'h18: begin p = 64'(sx * sy); {h, l} = p; end
            6'h19: begin p = {32'b0, x} * {32'b0, y}; {h, l} = p; end
            6'h1A: begin
                if (y == 0) begin l = '1; h = x; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin l = x; h = '0; end
                else begin l = 32'(sx / sy); h = 32'(sx % sy); end
            end
            default: begin
                if (y == 0) begin l = '1; h = x; end
                else begin l = x / y; h = x % y; end
            end
        endcase
    endtask

    // Scoreboard monitor: every out_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_out_valid: got result=%h aluctl=%0d, expected no output", result, aluctl);
            end else begin
                e = sb_q.pop_front();
                n_tests++;
                if (result !== e.res || aluctl !== e.ctl || ovf !== e.ovf || zero !== (e.res == '0)) begin
                    n_fail++;
                    $display("FAIL sb_result: got res=%h ctl=%0d ovf=%b zero=%b, expected res=%h ctl=%0d ovf=%b zero=%b",
                             result, aluctl, ovf, zero, e.res, e.ctl, e.ovf, (e.res == '0));
                end
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [SHW-1:0] sh);
        in_valid = 1'b1; aluop = op; funct = fn; a = x; b = y; shamt = sh;
    endtask

    // Offers one op, waits (bounded) for acceptance, records the expectation.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [SHW-1:0] sh, input exp_t e);
        drive(op, fn, x, y, sh);
        last_stalls = 0;
        @(negedge clk);
        while (!in_ready && last_stalls < 200) begin
            last_stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, last_stalls);
        end
        sb_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_md(output int busy);
        busy = 0;
        @(negedge clk);
        while (!in_ready && busy < 200) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || md_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got in_ready=%b out_valid=%b md_done=%b, expected 1 0 0", in_ready, out_valid, md_done);
        end
        n_tests++;
        if (result !== '0 || aluctl !== 4'd0 || ovf !== 1'b0 || zero !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got result=%h aluctl=%0d ovf=%b zero=%b hi=%h lo=%h, expected all 0",
                     result, aluctl, ovf, zero, hi, lo);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_add_ovf();
        issue(2'd2, 6'h20, 32'h7FFF_FFFF, 32'd1, 5'd0, mk(32'h8000_0000, 4'd2, 1'b1));
        issue(2'd2, 6'h21, 32'h7FFF_FFFF, 32'd1, 5'd0, mk(32'h8000_0000, 4'd2, 1'b0));
        issue(2'd2, 6'h22, 32'h8000_0000, 32'd1, 5'd0, mk(32'h7FFF_FFFF, 4'd6, 1'b1));
        issue(2'd0, 6'h20, 32'h7FFF_FFFF, 32'd1, 5'd0, mk(32'h8000_0000, 4'd2, 1'b0));
        issue(2'd2, 6'h03, 32'd0, 32'h8000_0010, 5'd4, mk(32'hF800_0001, 4'd5, 1'b0));
        idle(); settle();
    endtask

    task automatic test_back_to_back();
        int stalls_total;
        stalls_total = 0;
        issue(2'd1, 6'h00, 32'd5, 32'd5, 5'd0, mk(32'd0, 4'd6, 1'b0));
        stalls_total += last_stalls;
        issue(2'd2, 6'h27, 32'd0, 32'd0, 5'd0, mk(32'hFFFF_FFFF, 4'd12, 1'b0));
        stalls_total += last_stalls;
        issue(2'd2, 6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0, mk(32'd1, 4'd7, 1'b0));
        stalls_total += last_stalls;
        idle();
        n_tests++;
        if (stalls_total != 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %0d stall cycles in_ready=%b, expected 0 stalls in_ready=1", stalls_total, in_ready);
        end
        settle();
    endtask

    task automatic test_random_alu();
        logic [5:0]     fl [13];
        logic [1:0]     op;
        logic [5:0]     fn;
        logic [W-1:0]   x, y;
        logic [SHW-1:0] sh;
        fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        for (int i = 0; i < 24; i++) begin
            op = (i % 4 == 3) ? 2'($urandom_range(0, 3)) : 2'd2;
            fn = fl[$urandom_range(0, 12)];
            x  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            y  = (i % 7 == 0) ? 32'h7FFF_FFFF : $urandom;
            sh = 5'($urandom_range(0, 31));
            issue(op, fn, x, y, sh, alu_model(op, fn, x, y, sh));
        end
        issue(2'd2, 6'h3F, 32'd9, 32'd9, 5'd0, mk(32'd0, 4'd15, 1'b0));
        idle(); settle();
    endtask

    task automatic test_mult();
        int busy;
        issue(2'd2, 6'h18, 32'hFFFF_FFFD, 32'd7, 5'd0, mk(32'd0, 4'd14, 1'b0));
        drive(2'd2, 6'h10, 32'd0, 32'd0, 5'd0);
        wait_md(busy);
        n_tests++;
        if (busy != W + 1 || md_done !== 1'b1) begin
            n_fail++;
            $display("FAIL mult_latency: got busy=%0d md_done=%b, expected busy=%0d md_done=1", busy, md_done, W + 1);
        end
        n_tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_hilo: got hi=%h lo=%h, expected hi=ffffffff lo=ffffffeb", hi, lo);
        end
        sb_q.push_back(mk(32'hFFFF_FFFF, 4'd9, 1'b0));
        @(posedge clk); #1;
        issue(2'd2, 6'h12, 32'd0, 32'd0, 5'd0, mk(32'hFFFF_FFEB, 4'd10, 1'b0));
        idle(); settle();
    endtask

    task automatic md_case(input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
        int           busy;
        logic [W-1:0] eh, el;
        md_model(fn, x, y, eh, el);
        issue(2'd2, fn, x, y, 5'd0, mk(32'd0, 4'd14, 1'b0));
        idle();
        wait_md(busy);
        n_tests++;
        if (busy != W + 1 || md_done !== 1'b1 || hi !== eh || lo !== el) begin
            n_fail++;
            $display("FAIL md_%h_%h_%h: got busy=%0d md_done=%b hi=%h lo=%h, expected busy=%0d md_done=1 hi=%h lo=%h",
                     fn, x, y, busy, md_done, hi, lo, W + 1, eh, el);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        logic [5:0] fn;
        n_tests++;
        md_case(6'h1A, 32'hFFFF_FFF9, 32'd2);
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_neg7_2: got hi=%h lo=%h, expected hi=ffffffff lo=fffffffd", hi, lo);
        end
        n_tests++;
        md_case(6'h1B, 32'd7, 32'd0);
        if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin
            n_fail++;
            $display("FAIL divu_by0: got hi=%h lo=%h, expected hi=00000007 lo=ffffffff", hi, lo);
        end
        n_tests++;
        md_case(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL div_min_m1: got hi=%h lo=%h, expected hi=00000000 lo=80000000", hi, lo);
        end
        md_case(6'h1A, 32'hFFFF_FFF9, 32'd0);
        md_case(6'h18, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 6; i++) begin
            fn = 6'h18 + 6'($urandom_range(0, 3));
            md_case(fn, $urandom, (i == 2) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300))));
        end
        settle();
    endtask

    task automatic test_stall();
        int busy;
        issue(2'd2, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, mk(32'd0, 4'd14, 1'b0));
        drive(2'd0, 6'h3F, 32'd3, 32'd4, 5'd0);
        wait_md(busy);
        n_tests++;
        if (busy != W + 1 || md_done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_accept: got busy=%0d md_done=%b, expected busy=%0d md_done=1", busy, md_done, W + 1);
        end
        n_tests++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_hilo: got hi=%h lo=%h, expected hi=fffffffe lo=00000001", hi, lo);
        end
        sb_q.push_back(mk(32'd7, 4'd2, 1'b0));
        @(posedge clk); #1;
        idle(); settle();
    endtask

    task automatic test_reset_mid();
        int pulses;
        issue(2'd2, 6'h18, 32'd100, 32'd200, 5'd0, mk(32'd0, 4'd14, 1'b0));
        idle();
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || hi !== '0 || lo !== '0 || out_valid !== 1'b0 || md_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got in_ready=%b hi=%h lo=%h out_valid=%b md_done=%b, expected 1 0 0 0 0",
                     in_ready, hi, lo, out_valid, md_done);
        end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_done === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d md_done pulses, expected 0", pulses);
        end
        @(posedge clk); #1;
        issue(2'd2, 6'h12, 32'd0, 32'd0, 5'd0, mk(32'd0, 4'd10, 1'b0));
        idle(); settle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; aluop = '0; funct = '0; a = '0; b = '0; shamt = '0;
        test_reset();
        test_add_ovf();
        test_back_to_back();
        test_random_alu();
        test_mult();
        test_div();
        test_stall();
        test_reset_mid();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding expectations, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
